// File: rtl/change_dispenser_pkg.sv
// Shared types for the vending back end: FSM state encoding, coin codes, unit values.
// Optional hopper timeout (FAULT state) is present only when CHG_ACK_TIMEOUT_EN is defined.
package vending_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_SEL,
        S_REQ,
        S_REL,
`ifdef CHG_ACK_TIMEOUT_EN
        S_DONE,
        S_FAULT
`else
        S_DONE
`endif
    } state_e;

    localparam logic COIN_ONE = 1'b0;
    localparam logic COIN_TWO = 1'b1;

    localparam int UNIT_ONE  = 1;
    localparam int UNIT_TWO  = 2;
    localparam int UNIT_FIVE = 5;

    function automatic logic [1:0] coin_value(input logic sel);
        return (sel == COIN_TWO) ? 2'(UNIT_TWO) : 2'(UNIT_ONE);
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle between the vending front end / hopper (master) and change_dispenser (slave).
// Carries d/r request, 4-phase eject_req/eject_ack, vend, coin_sel and status flags.
interface change_dispenser_if #(
    parameter int CHG_W = 3
) ();
    logic             d;
    logic [CHG_W-1:0] r;
    logic             eject_ack;
    logic             vend;
    logic             eject_req;
    logic             coin_sel;
    logic             busy;
    logic             done;
    logic             lost;
    logic             fault;

    modport master (
        output d, r, eject_ack,
        input  vend, eject_req, coin_sel, busy, done, lost, fault
    );

    modport slave (
        input  d, r, eject_ack,
        output vend, eject_req, coin_sel, busy, done, lost, fault
    );
endinterface

// File: rtl/hs_wait_timer.sv
// Loadable saturating down-counter; zero flags an expired count.
// Ports: clk, reset (async active-low), load/load_val, dec, zero.
module hs_wait_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/change_dispenser.sv
// Vend motor sequencing plus greedy change payout over a 4-phase hopper handshake.
// Ports: clk, reset (async active-low), bus (slave). Option: CHG_ACK_TIMEOUT_EN.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int CHG_W    = 3,
    parameter int VEND_CYC = 4,
    parameter int ACK_TO   = 16
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave bus
);
    localparam int TMAX = (VEND_CYC > ACK_TO) ? VEND_CYC : ACK_TO;
    localparam int TW   = $clog2(TMAX) + 1;

    state_e           state_q, state_d;
    logic [CHG_W-1:0] rem_q, rem_d;
    logic             sel_q, sel_d;
    logic             lost_q, lost_d;
    logic             vend_q, vend_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_dec;
    logic          tmr_zero;

    hs_wait_timer #(.W(TW)) u_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        sel_d    = sel_q;
        lost_d   = lost_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        if (state_q != S_IDLE && (bus.d || bus.r != '0)) lost_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.d) begin
                    rem_d    = bus.r;
                    state_d  = S_VEND;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(VEND_CYC - 1);
                end else if (bus.r != '0) begin
                    rem_d   = bus.r;
                    state_d = S_SEL;
                end
            end
            S_VEND: begin
                if (tmr_zero) state_d = S_SEL;
                else          tmr_dec = 1'b1;
            end
            S_SEL: begin
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    // Greedy: a 2-unit coin whenever it fits, so rem never underflows.
                    sel_d    = (rem_q >= CHG_W'(2)) ? COIN_TWO : COIN_ONE;
                    state_d  = S_REQ;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ACK_TO - 1);
                end
            end
            S_REQ: begin
                if (bus.eject_ack) begin
                    rem_d    = rem_q - CHG_W'(coin_value(sel_q));
                    state_d  = S_REL;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ACK_TO - 1);
                end
`ifdef CHG_ACK_TIMEOUT_EN
                else if (tmr_zero) state_d = S_FAULT;
`endif
                else tmr_dec = 1'b1;
            end
            S_REL: begin
                if (!bus.eject_ack) state_d = S_SEL;
`ifdef CHG_ACK_TIMEOUT_EN
                else if (tmr_zero) state_d = S_FAULT;
`endif
                else tmr_dec = 1'b1;
            end
            S_DONE: state_d = S_IDLE;
`ifdef CHG_ACK_TIMEOUT_EN
            S_FAULT: state_d = S_FAULT;
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered decodes of the next state.
        vend_d = (state_d == S_VEND);
        req_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            sel_q   <= COIN_ONE;
            lost_q  <= 1'b0;
            vend_q  <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            lost_q  <= lost_d;
            vend_q  <= vend_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CHG_ACK_TIMEOUT_EN
    logic fault_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fault_q <= 1'b0;
        else        fault_q <= (state_d == S_FAULT);
    end
    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    assign bus.vend      = vend_q;
    assign bus.eject_req = req_q;
    assign bus.coin_sel  = sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.lost      = lost_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Random-transaction bench for change_dispenser with a randomly delayed hopper.
// Expected vend length, coin sequence and latency come from plain arithmetic on d/r.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    change_dispenser_if #(.CHG_W(3)) bus ();

    change_dispenser #(
        .CHG_W    (3),
        .VEND_CYC (4),
        .ACK_TO   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One transaction: request for one cycle, act as hopper, observe to done.
    task automatic run_txn(input logic dd, input int rr, input bit inj);
        int cyc, vcnt, ncoin, first, dly, twos, ones;
        logic [31:0] seq, exp_seq;
        bit seen_done, prev_req, unstable;
        logic prev_sel;
        cyc = 1; vcnt = 0; ncoin = 0; first = -1; seq = 0;
        seen_done = 0; prev_req = 0; unstable = 0; prev_sel = 0;
        dly = $urandom_range(0, 3);
        @(negedge clk);
        bus.d = dd;
        bus.r = rr[2:0];
        @(negedge clk);
        bus.d = 1'b0;
        bus.r = '0;
        while (!seen_done && cyc < 300) begin
            bus.d = (inj && cyc == 2);
            if (bus.vend) vcnt++;
            if (bus.eject_req && !prev_req) begin
                ncoin++;
                seq = (seq << 1) | 32'(bus.coin_sel);
                if (first < 0) first = cyc;
            end
            if (bus.eject_req && prev_req && bus.coin_sel !== prev_sel) unstable = 1;
            prev_req = bus.eject_req;
            prev_sel = bus.coin_sel;
            if (bus.eject_ack !== bus.eject_req) begin
                if (dly == 0) begin
                    bus.eject_ack = bus.eject_req;
                    dly = $urandom_range(0, 3);
                end else begin
                    dly--;
                end
            end
            if (bus.done) seen_done = 1;
            @(negedge clk);
            cyc++;
        end
        bus.d = 1'b0;
        twos = rr / 2;
        ones = rr % 2;
        exp_seq = ((32'd1 << twos) - 1) << ones;
        check("done_seen", 32'(seen_done), 1);
        check("vend_cycles", vcnt, dd ? 4 : 0);
        check("coin_count", ncoin, twos + ones);
        check("coin_seq", seq, exp_seq);
        check("req_latency", first, (rr == 0) ? -1 : (dd ? 6 : 2));
        check("sel_stable", 32'(unstable), 0);
        check("busy_after", 32'(bus.busy), 0);
        check("done_pulse", 32'(bus.done), 0);
    endtask

    initial begin
        int k, rr, cnt;
        logic dd;
        bus.d = 1'b0;
        bus.r = '0;
        bus.eject_ack = 1'b0;
        #12;
        check("rst_vend", 32'(bus.vend), 0);
        check("rst_req", 32'(bus.eject_req), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_lost", 32'(bus.lost), 0);
        check("rst_fault", 32'(bus.fault), 0);
        check("rst_sel", 32'(bus.coin_sel), 0);
        @(negedge clk);
        reset = 1'b1;

        run_txn(1'b1, 0, 1'b0);
        run_txn(1'b1, 3, 1'b0);
        run_txn(1'b0, 4, 1'b0);
        run_txn(1'b0, 7, 1'b0);
        for (int i = 0; i < 20; i++) begin
            dd = 1'($urandom_range(0, 1));
            rr = $urandom_range(0, 7);
            if (!dd && rr == 0) dd = 1'b1;
            run_txn(dd, rr, 1'b0);
        end
        check("lost_clear", 32'(bus.lost), 0);

        run_txn(1'b1, 1, 1'b1);
        check("lost_set", 32'(bus.lost), 1);
        repeat (3) @(negedge clk);
        check("lost_sticky", 32'(bus.lost), 1);

        // Reset in the middle of a handshake with ack withheld.
        @(negedge clk);
        bus.r = 3'd3;
        @(negedge clk);
        bus.r = '0;
        k = 0;
        while (!bus.eject_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("req_before_rst", 32'(bus.eject_req), 1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_req", 32'(bus.eject_req), 0);
        check("rst_mid_busy", 32'(bus.busy), 0);
        check("rst_mid_lost", 32'(bus.lost), 0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.eject_req || bus.busy) cnt++;
        end
        check("no_residual", cnt, 0);

`ifdef CHG_ACK_TIMEOUT_EN
        @(negedge clk);
        bus.r = 3'd2;
        @(negedge clk);
        bus.r = '0;
        cnt = 0;
        k = 0;
        while (!bus.fault && k < 60) begin
            if (bus.eject_req) cnt++;
            @(negedge clk);
            k++;
        end
        check("fault_req_cycles", cnt, 16);
        check("fault_set", 32'(bus.fault), 1);
        check("fault_req_low", 32'(bus.eject_req), 0);
        check("fault_busy", 32'(bus.busy), 1);
        repeat (5) @(negedge clk);
        check("fault_sticky", 32'(bus.fault), 1);
        check("fault_req_held", 32'(bus.eject_req), 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("fault_cleared", 32'(bus.fault), 0);
`else
        // Withheld ack: no timeout exists, so it must stay waiting.
        @(negedge clk);
        bus.r = 3'd2;
        @(negedge clk);
        bus.r = '0;
        repeat (30) @(negedge clk);
        check("hang_req", 32'(bus.eject_req), 1);
        check("fault_tied", 32'(bus.fault), 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
`endif
        run_txn(1'b1, 5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
